// File: rtl/frac_divider_hs.sv
// Multi-cycle signed-by-unsigned fractional divider (restoring, radix 2^BITS_PER_CYCLE)
// with valid/ready handshake, optional rounding, symmetric saturation and tag pass-through.
module frac_divider_hs #(
  parameter int OPERAND_BITS   = 30,
  parameter int RESULT_BITS    = 25,
  parameter int BITS_PER_CYCLE = 1,
  parameter int ROUND          = 0,
  parameter int TAG_BITS       = 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    CE,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  input  logic [OPERAND_BITS-1:0] A_IN,
  input  logic [OPERAND_BITS-1:0] B_IN,
  input  logic [TAG_BITS-1:0]     TAG_IN,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic [RESULT_BITS-1:0]  Q_OUT,
  output logic [TAG_BITS-1:0]     TAG_OUT,
  output logic                    OVF,
  output logic                    DIVZ
);

  localparam int M  = RESULT_BITS - 1 + ROUND;
  localparam int N  = (M + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
  localparam int K  = N * BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam int RW = OPERAND_BITS + 1;
  localparam int MW = RESULT_BITS + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_r;
  logic [RW-1:0]           rem_r;
  logic [OPERAND_BITS-1:0] div_r;
  logic [K-1:0]            quo_r;
  logic [CW-1:0]           cnt_r;
  logic [TAG_BITS-1:0]     tag_r;
  logic                    neg_r;
  logic                    zero_r;
  logic                    ovf_r;
  logic                    divz_r;

  logic [OPERAND_BITS-1:0] a_abs_s;
  logic                    pre_sat_s;
  logic [RW-1:0]           rem_s;
  logic [K-1:0]            quo_s;
  logic [K-1:0]            qm_s;
  logic [MW-1:0]           mag_s;
  logic                    rovf_s;
  logic [RESULT_BITS-1:0]  sat_s;
  logic [RESULT_BITS-1:0]  q_s;
  logic                    ovf_s;

  assign IN_READY = CE & (state_r == S_IDLE);
  assign sat_s    = {1'b0, {(RESULT_BITS-1){1'b1}}};

  // Operand magnitude and early overflow / divide-by-zero detection at accept time
  always_comb begin
    if (A_IN[OPERAND_BITS-1]) begin
      a_abs_s = ~A_IN + {{(OPERAND_BITS-1){1'b0}}, 1'b1};
    end else begin
      a_abs_s = A_IN;
    end
    pre_sat_s = (B_IN == {OPERAND_BITS{1'b0}}) || (a_abs_s >= B_IN);
  end

  // One radix-2^BITS_PER_CYCLE restoring step plus final rounding and saturation
  always_comb begin
    rem_s = rem_r;
    quo_s = quo_r;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      rem_s = {rem_s[RW-2:0], 1'b0};
      if (rem_s >= {1'b0, div_r}) begin
        rem_s = rem_s - {1'b0, div_r};
        quo_s = {quo_s[K-2:0], 1'b1};
      end else begin
        quo_s = {quo_s[K-2:0], 1'b0};
      end
    end
    // Drop the surplus low bits produced when K exceeds the magnitude width
    qm_s = quo_s >> (K - M);
    if (ROUND != 0) begin
      mag_s = MW'(qm_s >> 1) + MW'(qm_s[0]);
    end else begin
      mag_s = MW'(qm_s);
    end
    rovf_s = (mag_s > {1'b0, sat_s});
    if (divz_r) begin
      if (zero_r) begin
        q_s = {RESULT_BITS{1'b0}};
      end else if (neg_r) begin
        q_s = -sat_s;
      end else begin
        q_s = sat_s;
      end
    end else if (ovf_r || rovf_s) begin
      if (neg_r) begin
        q_s = -sat_s;
      end else begin
        q_s = sat_s;
      end
    end else if (neg_r) begin
      q_s = -mag_s[RESULT_BITS-1:0];
    end else begin
      q_s = mag_s[RESULT_BITS-1:0];
    end
    ovf_s = !divz_r && (ovf_r || rovf_s);
  end

  // Handshake FSM, iteration datapath and registered result outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r   <= S_IDLE;
      rem_r     <= {RW{1'b0}};
      div_r     <= {OPERAND_BITS{1'b0}};
      quo_r     <= {K{1'b0}};
      cnt_r     <= {CW{1'b0}};
      tag_r     <= {TAG_BITS{1'b0}};
      neg_r     <= 1'b0;
      zero_r    <= 1'b0;
      ovf_r     <= 1'b0;
      divz_r    <= 1'b0;
      OUT_VALID <= 1'b0;
      Q_OUT     <= {RESULT_BITS{1'b0}};
      TAG_OUT   <= {TAG_BITS{1'b0}};
      OVF       <= 1'b0;
      DIVZ      <= 1'b0;
    end else if (CE) begin
      case (state_r)
        S_IDLE: begin
          if (IN_VALID) begin
            // Saturating cases still run N steps from a zero remainder to keep latency fixed
            rem_r   <= pre_sat_s ? {RW{1'b0}} : {1'b0, a_abs_s};
            div_r   <= B_IN;
            quo_r   <= {K{1'b0}};
            cnt_r   <= CW'(N - 1);
            tag_r   <= TAG_IN;
            neg_r   <= A_IN[OPERAND_BITS-1];
            zero_r  <= (A_IN == {OPERAND_BITS{1'b0}});
            divz_r  <= (B_IN == {OPERAND_BITS{1'b0}});
            ovf_r   <= (B_IN != {OPERAND_BITS{1'b0}}) && (a_abs_s >= B_IN);
            state_r <= S_RUN;
          end
        end
        S_RUN: begin
          rem_r <= rem_s;
          quo_r <= quo_s;
          if (cnt_r == {CW{1'b0}}) begin
            Q_OUT     <= q_s;
            TAG_OUT   <= tag_r;
            OVF       <= ovf_s;
            DIVZ      <= divz_r;
            OUT_VALID <= 1'b1;
            state_r   <= S_DONE;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        S_DONE: begin
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            state_r   <= S_IDLE;
          end
        end
        default: begin
          OUT_VALID <= 1'b0;
          state_r   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frac_divider_hs.sv
// Bench for frac_divider_hs: four parameter variants against a transaction-level
// arithmetic reference model, directed spec cases plus randomized CE/handshake/reset traffic.
module tb_frac_divider_hs;
  localparam int OB = 30;
  localparam int RB = 25;
  localparam int TW = 4;
  localparam int NI = 4;
  localparam int BPC_T [NI] = '{1, 2, 4, 1};
  localparam int RND_T [NI] = '{0, 0, 0, 1};
  localparam int LAT_T [NI] = '{24, 12, 6, 25};

  logic          CLK = 1'b0;
  logic          RESET;
  logic          CE;
  logic [OB-1:0] a_in;
  logic [OB-1:0] b_in;
  logic [TW-1:0] tag_in;
  logic          in_valid  [NI];
  logic          in_ready  [NI];
  logic          out_valid [NI];
  logic          out_ready [NI];
  logic          ovf       [NI];
  logic          divz      [NI];
  logic [RB-1:0] q_out     [NI];
  logic [TW-1:0] tag_out   [NI];

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    frac_divider_hs #(
      .OPERAND_BITS(OB), .RESULT_BITS(RB), .BITS_PER_CYCLE(BPC_T[g]),
      .ROUND(RND_T[g]), .TAG_BITS(TW)
    ) u_dut (
      .CLK(CLK), .RESET(RESET), .CE(CE),
      .IN_VALID(in_valid[g]), .IN_READY(in_ready[g]),
      .A_IN(a_in), .B_IN(b_in), .TAG_IN(tag_in),
      .OUT_VALID(out_valid[g]), .OUT_READY(out_ready[g]),
      .Q_OUT(q_out[g]), .TAG_OUT(tag_out[g]), .OVF(ovf[g]), .DIVZ(divz[g])
    );
  end

  int vectors = 0;
  int miscompares = 0;

  // transaction-level model state
  bit            live = 1'b0;
  bit            busy [NI];
  bit            mv   [NI];
  int            cnt  [NI];
  logic [RB-1:0] mq [NI], pq [NI];
  logic [TW-1:0] mtag [NI], ptag [NI];
  bit            movf [NI], povf [NI], mdivz [NI], pdivz [NI];

  function automatic void ref_div(input logic signed [OB-1:0] a, input logic [OB-1:0] b,
                                  input int rnd, output logic [RB-1:0] q,
                                  output bit o, output bit d);
    longint maxv = 64'sd16777215;
    longint mag_a;
    longint m;
    mag_a = (a < 0) ? -longint'(a) : longint'(a);
    o = 1'b0;
    d = 1'b0;
    if (b == 0) begin
      d = 1'b1;
      m = (mag_a == 0) ? 64'sd0 : maxv;
    end else if (mag_a >= longint'(b)) begin
      o = 1'b1;
      m = maxv;
    end else begin
      if (rnd != 0) m = (((mag_a <<< 25) / longint'(b)) + 64'sd1) >>> 1;
      else          m = (mag_a <<< 24) / longint'(b);
      if (m > maxv) begin
        m = maxv;
        o = 1'b1;
      end
    end
    q = (a < 0) ? RB'(-m) : RB'(m);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    if (live) begin
      for (int g = 0; g < NI; g++) begin
        chk($sformatf("dut%0d vld/rdy/ovf/divz/tag/q", g),
            {out_valid[g], in_ready[g], ovf[g], divz[g], tag_out[g], q_out[g]},
            {mv[g], CE & ~busy[g], movf[g], mdivz[g], mtag[g], mq[g]});
      end
    end
  endtask

  // advance the model across the coming clock edge using the inputs now applied
  task automatic model_step();
    for (int g = 0; g < NI; g++) begin
      if (RESET) begin
        busy[g] = 1'b0; mv[g] = 1'b0; cnt[g] = 0; mq[g] = '0;
        mtag[g] = '0; movf[g] = 1'b0; mdivz[g] = 1'b0;
      end else if (CE) begin
        if (mv[g]) begin
          if (out_ready[g]) begin
            mv[g] = 1'b0;
            busy[g] = 1'b0;
          end
        end else if (busy[g]) begin
          cnt[g]--;
          if (cnt[g] == 0) begin
            mv[g] = 1'b1; mq[g] = pq[g]; mtag[g] = ptag[g];
            movf[g] = povf[g]; mdivz[g] = pdivz[g];
          end
        end else if (in_valid[g]) begin
          busy[g] = 1'b1;
          cnt[g] = (RB - 1 + RND_T[g] + BPC_T[g] - 1) / BPC_T[g];
          ref_div(a_in, b_in, RND_T[g], pq[g], povf[g], pdivz[g]);
          ptag[g] = tag_in;
        end
      end
    end
    if (RESET) live = 1'b1;
  endtask

  task automatic cycle();
    @(negedge CLK);
    compare();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_all(input bit iv, input bit orr);
    for (int g = 0; g < NI; g++) begin
      in_valid[g] = iv;
      out_ready[g] = orr;
    end
  endtask

  // issue one operation to every variant and wait until all hold their result
  task automatic run_one(input logic [OB-1:0] a, input logic [OB-1:0] b, input logic [TW-1:0] t);
    a_in = a; b_in = b; tag_in = t;
    set_all(1'b1, 1'b0);
    cycle();
    set_all(1'b0, 1'b0);
    repeat (26) cycle();
  endtask

  task automatic pop_all();
    set_all(1'b0, 1'b1);
    cycle();
    set_all(1'b0, 1'b0);
  endtask

  logic [RB-1:0] mdl_q;
  bit            mdl_o, mdl_d;
  int            lat [NI];
  logic [OB-1:0] dir_a [8];
  logic [OB-1:0] dir_b [8];
  logic [OB-1:0] rb, rmag;
  logic [31:0]   r32;
  int            mode;

  initial begin
    RESET = 1'b1; CE = 1'b1; a_in = '0; b_in = '0; tag_in = '0;
    set_all(1'b0, 1'b0);

    // hand-computed values pinning the reference model
    ref_div(30'sd1, 30'd2, 0, mdl_q, mdl_o, mdl_d);
    chk("model 1/2", {mdl_o, mdl_d, mdl_q}, {2'b00, 25'd8388608});
    ref_div(-30'sd1, 30'd4, 0, mdl_q, mdl_o, mdl_d);
    chk("model -1/4", {mdl_o, mdl_d, mdl_q}, {2'b00, 25'h1C00000});
    ref_div(30'sd2, 30'd3, 0, mdl_q, mdl_o, mdl_d);
    chk("model 2/3 trunc", {mdl_o, mdl_d, mdl_q}, {2'b00, 25'd11184810});
    ref_div(30'sd2, 30'd3, 1, mdl_q, mdl_o, mdl_d);
    chk("model 2/3 round", {mdl_o, mdl_d, mdl_q}, {2'b00, 25'd11184811});
    ref_div(30'sd5, 30'd5, 0, mdl_q, mdl_o, mdl_d);
    chk("model 5/5", {mdl_o, mdl_d, mdl_q}, {2'b10, 25'd16777215});
    ref_div(-30'sd5, 30'd5, 0, mdl_q, mdl_o, mdl_d);
    chk("model -5/5", {mdl_o, mdl_d, mdl_q}, {2'b10, 25'h1000001});
    ref_div(30'sd7, 30'd0, 0, mdl_q, mdl_o, mdl_d);
    chk("model 7/0", {mdl_o, mdl_d, mdl_q}, {2'b01, 25'd16777215});
    ref_div(30'sd0, 30'd0, 0, mdl_q, mdl_o, mdl_d);
    chk("model 0/0", {mdl_o, mdl_d, mdl_q}, {2'b01, 25'd0});

    repeat (3) cycle();
    chk("reset q dut0", {out_valid[0], ovf[0], divz[0], tag_out[0], q_out[0]}, 64'd0);
    RESET = 1'b0;
    cycle();

    // latency per variant for A=1,B=3
    a_in = 30'd1; b_in = 30'd3; tag_in = 4'h3;
    set_all(1'b1, 1'b0);
    cycle();
    set_all(1'b0, 1'b0);
    for (int g = 0; g < NI; g++) lat[g] = 0;
    for (int k = 1; k <= 40; k++) begin
      cycle();
      for (int g = 0; g < NI; g++) if (out_valid[g] && lat[g] == 0) lat[g] = k;
    end
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("latency dut%0d", g), 64'(lat[g]), 64'(LAT_T[g]));
      chk($sformatf("1/3 q dut%0d", g), 64'(q_out[g]), 64'd5592405);
    end
    pop_all();

    dir_a = '{30'd1, 30'h3FFFFFFF, 30'd2, 30'd5, -30'sd5, 30'd7, 30'd0, 30'h20000000};
    dir_b = '{30'd2, 30'd4, 30'd3, 30'd5, 30'd5, 30'd0, 30'd0, 30'h3FFFFFFF};
    for (int i = 0; i < 8; i++) begin
      run_one(dir_a[i], dir_b[i], 4'(i));
      if (i == 2) begin
        chk("2/3 trunc dut0", 64'(q_out[0]), 64'd11184810);
        chk("2/3 round dut3", 64'(q_out[3]), 64'd11184811);
      end
      pop_all();
    end

    // backpressure: result and tag held, no new accept
    run_one(30'd3, 30'd7, 4'hA);
    ref_div(30'sd3, 30'd7, 0, mdl_q, mdl_o, mdl_d);
    repeat (10) cycle();
    chk("bp q dut0", 64'(q_out[0]), 64'(mdl_q));
    chk("bp tag/vld/rdy dut1", {tag_out[1], out_valid[1], in_ready[1]}, {4'hA, 1'b1, 1'b0});
    pop_all();

    // reset in the middle of RUN aborts every variant
    run_one(30'd9, 30'd11, 4'h5);
    pop_all();
    a_in = 30'd9; b_in = 30'd13; tag_in = 4'h6;
    set_all(1'b1, 1'b0);
    cycle();
    set_all(1'b0, 1'b1);
    repeat (4) cycle();
    RESET = 1'b1;
    cycle();
    RESET = 1'b0;
    chk("abort rdy/vld", {in_ready[0], in_ready[1], in_ready[2], in_ready[3],
                          out_valid[0], out_valid[1], out_valid[2], out_valid[3]}, 64'hF0);
    repeat (30) cycle();

    // randomized traffic
    for (int n = 0; n < 10000; n++) begin
      CE = ($urandom_range(0, 3) != 0);
      RESET = ($urandom_range(0, 499) == 0);
      for (int g = 0; g < NI; g++) begin
        in_valid[g] = ($urandom_range(0, 1) == 1);
        out_ready[g] = ($urandom_range(0, 3) != 0);
      end
      mode = $urandom_range(0, 9);
      r32 = $urandom;
      rb = OB'(r32);
      if (mode == 0) rb = '0;
      else if (mode == 1) rb = OB'($urandom_range(1, 15));
      r32 = $urandom;
      rmag = (rb > 1) ? OB'(r32 % {2'b00, rb}) : '0;
      if (mode == 2) rmag = OB'($urandom) & 30'h1FFFFFFF;
      if (mode == 4 && rb != 0) rmag = rb - 30'd1;
      if (mode == 5) rmag = '0;
      a_in = ($urandom_range(0, 1) == 1) ? -rmag : rmag;
      if (mode == 3) a_in = 30'h20000000;
      b_in = rb;
      tag_in = TW'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
